pipelined_adder: RTL and testbench
==================================

Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the combinational 16-bit ripple-carry adder.
- Splits a WIDTH-bit add into STAGES equal chunks and registers the carry between chunks, so one chunk of carry ripple sits in each clock period.
- Accepts one operand pair per cycle through a valid/ready handshake with backpressure.
- Used by the Hack datapath wherever a registered wide adder is needed (PC increment, ALU add path at wider widths).

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages; chunk width CW = WIDTH/STAGES; STAGES >= 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset, sampled on the clk rising edge.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for the transaction.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

Behaviour:
- Reset, synchronous and active-high: every stage valid bit cleared; out_valid=0, sum=0, cout=0 (ovf=0 when present). in_ready=1 in the first cycle after reset.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Stall: stall = out_valid && !out_ready; in_ready = !stall.
  - During stall every pipeline register holds, including data, carries and valids.
  - sum and cout stay stable; no transaction is lost or duplicated.
- Stage k (0..STAGES-1) adds chunk k of a and b plus its incoming carry. Stage 0 uses cin; stage k uses the registered carry from stage k-1.
- Input skew: upper operand chunks are delayed in skew registers so that chunk k meets its carry in stage k.
- Output deskew: lower sum chunks are delayed so all WIDTH bits of sum appear together.
- Latency: exactly STAGES cycles from input transfer to out_valid, when not stalled. STAGES=1 gives a single registered full add.
- Throughput: one transaction per cycle when out_ready=1.
- Bubbles: in_valid=0 inserts a bubble that propagates as valid=0; bubble stages may update (data don't-care) when not stalled.
- Ordering: results leave strictly in acceptance order.
- Simultaneous input and output transfer in the same cycle is legal and required for full throughput.
- Reset mid-operation: all in-flight transactions are discarded; reset has priority over stall and over input transfer.
- out_valid, sum and cout are driven from registers, with no combinational path from the inputs. in_ready depends combinationally on out_ready.
- Wrap-around: sum is modulo 2^WIDTH; overflow beyond WIDTH appears only on cout.

Optional Feature:
- Macro: PIPELINED_ADDER_OVF_EN.
- When defined, adds output port ovf (1 bit): signed two's-complement overflow, equal to the carry into bit WIDTH-1 XOR cout.
  - ovf is registered and aligned with sum and cout.
  - ovf reset value is 0; it holds during stall.
- When not defined, the ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=16, STAGES=4, out_ready=1: a=0x1234, b=0x4321, cin=0 -> after exactly 4 cycles out_valid=1, sum=0x5555, cout=0.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry crosses all 4 stages); a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
- Four back-to-back transfers (0x0001+0x0001, 0x00FF+0x0001, 0x0FFF+0x0001, 0xFFFF+0xFFFF), out_ready=1 -> out_valid high for 4 consecutive cycles with sum 0x0002, 0x0100, 0x1000, 0xFFFE (cout=1 on the last), in order.
- Result pending with out_ready=0 for 3 cycles and in_valid=1 held -> in_ready=0 for those 3 cycles, sum and cout unchanged; after out_ready=1 every transaction is delivered once, in order.
- reset asserted for 1 cycle while 3 transactions are in flight -> next cycle out_valid=0, sum=0, cout=0; no stale result ever appears; a new transaction after reset completes with latency 4.
- With PIPELINED_ADDER_OVF_EN: 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0; 0x8000+0xFFFF -> sum=0x7FFF, ovf=1, cout=1; 0x0003+0xFFFF -> sum=0x0002, ovf=0, cout=1.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder: one CW-bit carry-ripple chunk per stage, valid/ready with backpressure.
// Optional signed-overflow output enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = WIDTH / STAGES;

    logic stall;

    // A result held at the output freezes the whole pipeline.
    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_i, b_i, s_i, s_n;
        logic [WIDTH-1:0] a_r, b_r, s_r;
        logic             c_i, v_i, c_r, v_r;
        logic [CW:0]      chunk;

        if (k == 0) begin : g_head
            assign a_i = a;
            assign b_i = b;
            assign s_i = '0;
            assign c_i = cin;
            assign v_i = in_valid;
        end else begin : g_tail
            assign a_i = g_stage[k-1].a_r;
            assign b_i = g_stage[k-1].b_r;
            assign s_i = g_stage[k-1].s_r;
            assign c_i = g_stage[k-1].c_r;
            assign v_i = g_stage[k-1].v_r;
        end

        // Operands travel along with the partial sum, so upper chunks are skewed
        // and finished lower chunks are deskewed by the same registers.
        assign chunk = (CW+1)'(a_i[k*CW +: CW]) + (CW+1)'(b_i[k*CW +: CW]) + (CW+1)'(c_i);

        always_comb begin
            s_n                = s_i;
            s_n[k*CW +: CW]    = chunk[CW-1:0];
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                a_r <= '0;
                b_r <= '0;
                s_r <= '0;
            end else if (!stall) begin
                v_r <= v_i;
                c_r <= chunk[CW];
                a_r <= a_i;
                b_r <= b_i;
                s_r <= s_n;
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].v_r;
    assign sum       = g_stage[STAGES-1].s_r;
    assign cout      = g_stage[STAGES-1].c_r;

    // Operand copies leaving the last stage have no consumer.
    logic unused_ops;
    assign unused_ops = ^{g_stage[STAGES-1].a_r, g_stage[STAGES-1].b_r};

`ifdef PIPELINED_ADDER_OVF_EN
    // Carry into the MSB recovered from the MSB sum bit, XORed with carry out.
    logic ovf_n;
    assign ovf_n = (g_stage[STAGES-1].a_i[WIDTH-1] ^ g_stage[STAGES-1].b_i[WIDTH-1]
                    ^ g_stage[STAGES-1].chunk[CW-1]) ^ g_stage[STAGES-1].chunk[CW];

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf <= 1'b0;
        end else if (!stall) begin
            ovf <= ovf_n;
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder: directed cases plus randomized traffic vs. a queue model.
module tb_pipelined_adder;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned STAGES = 4;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef PIPELINED_ADDER_OVF_EN
    logic             ovf;
`endif

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef PIPELINED_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic prev_stall = 1'b0;
    logic [WIDTH:0] prev_out = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer addition and the sign rule for two's-complement overflow.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic c);
        logic [WIDTH:0] t;
        exp_t e;
        t   = (WIDTH+1)'(x) + (WIDTH+1)'(y) + (WIDTH+1)'(c);
        e.s = t[WIDTH-1:0];
        e.c = t[WIDTH];
        e.o = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
        return e;
    endfunction

    // Scoreboard: inputs are stable between #1 after posedge and the next posedge.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            check("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'({cout, sum}), 32'(prev_out));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sum", 32'(sum), 32'(e.s));
                    check("cout", 32'(cout), 32'(e.c));
`ifdef PIPELINED_ADDER_OVF_EN
                    check("ovf", 32'(ovf), 32'(e.o));
`endif
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin));
            prev_stall = out_valid && !out_ready;
            prev_out   = {cout, sum};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operand pair and return just after the edge that accepts it.
    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c);
        logic acc;
        int   guard;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        cin      = c;
        guard    = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            tick();
            guard++;
        end while (!acc && guard < 50);
        if (!acc) check("send_timeout", 32'(acc), 32'd1);
    endtask

    task automatic latency_case(input string tag, input logic [WIDTH-1:0] x,
                                input logic [WIDTH-1:0] y, input logic c);
        int   lat;
        exp_t e;
        e         = model(x, y, c);
        out_ready = 1'b1;
        send(x, y, c);
        in_valid  = 1'b0;
        lat       = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(STAGES));
        check({tag, "_result"}, 32'({cout, sum}), 32'({e.c, e.s}));
        tick();
    endtask

    initial begin
        logic [WIDTH-1:0] b2b_a[4];
        logic [WIDTH-1:0] b2b_b[4];
        logic [WIDTH:0]   b2b_e[4];
        int               guard;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPELINED_ADDER_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif

        latency_case("basic", 16'h1234, 16'h4321, 1'b0);
        latency_case("carry_all", 16'hFFFF, 16'h0001, 1'b0);
        latency_case("cin_only", 16'h0000, 16'h0000, 1'b1);
        latency_case("ovf_pos", 16'h7FFF, 16'h0001, 1'b0);
        latency_case("ovf_neg", 16'h8000, 16'hFFFF, 1'b0);
        latency_case("no_ovf", 16'h0003, 16'hFFFF, 1'b0);

        // Back-to-back: four results on four consecutive cycles.
        b2b_a = '{16'h0001, 16'h00FF, 16'h0FFF, 16'hFFFF};
        b2b_b = '{16'h0001, 16'h0001, 16'h0001, 16'hFFFF};
        b2b_e = '{17'h00002, 17'h00100, 17'h01000, 17'h1FFFE};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send(b2b_a[i], b2b_b[i], 1'b0);
        in_valid = 1'b0;
        guard    = 0;
        while (!out_valid && guard < 20) begin
            tick();
            guard++;
        end
        for (int i = 0; i < 4; i++) begin
            check("b2b_valid", 32'(out_valid), 32'd1);
            check("b2b_result", 32'({cout, sum}), 32'(b2b_e[i]));
            tick();
        end
        check("b2b_gap", 32'(out_valid), 32'd0);

        // Backpressure: output held three cycles with a fifth pair waiting.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
        in_valid = 1'b1;
        a        = 16'hBEEF;
        b        = 16'h4111;
        cin      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        send(16'hBEEF, 16'h4111, 1'b1);
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("stall_drained", 32'(exp_q.size()), 32'd0);

        // Reset with three transactions in flight.
        for (int i = 0; i < 3; i++) send(WIDTH'($urandom), WIDTH'($urandom), 1'b0);
        in_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        latency_case("post_reset", 16'h00F0, 16'h0F10, 1'b0);

        // Randomized traffic with random backpressure and bubbles.
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 5))
                0:       a = 16'hFFFF;
                1:       a = 16'h7FFF;
                default: a = WIDTH'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       b = 16'h0001;
                1:       b = 16'h8000;
                default: b = WIDTH'($urandom);
            endcase
            cin = 1'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("random_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
